// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared add/subtract datapath.
// Optional signed-overflow flag output res_ovf enabled by defining ADDSUB_ARBITER_OVF_EN.
module addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_add_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_add_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
`ifdef ADDSUB_ARBITER_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             ptr_r;
  logic             ptr_next_s;
  logic             grant0_s;
  logic             grant1_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             add_sub_r;
  logic             id_r;
  logic [WIDTH-1:0] sum_s;
  logic             res_valid_r;
  logic [WIDTH-1:0] res_data_r;
  logic             res_id_r;

  // Modulo-2^WIDTH add or subtract; subtraction wraps on underflow.
  function automatic logic [WIDTH-1:0] addsub_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             add
  );
    logic [WIDTH-1:0] r;
    if (add) begin
      r = a + b;
    end else begin
      r = a - b;
    end
    return r;
  endfunction

  assign sum_s = addsub_sum(a_r, b_r, add_sub_r);

  // Next-state, grant and pointer logic; grants are only issued from IDLE outside reset.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (reset) begin
          state_next_s = IDLE;
        end else if (req0_valid && (!req1_valid || !ptr_r)) begin
          grant0_s     = 1'b1;
          state_next_s = EXEC;
        end else if (req1_valid) begin
          grant1_s     = 1'b1;
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        state_next_s = DONE;
      end
      DONE: begin
        if (res_valid_r && res_ready) begin
          state_next_s = IDLE;
          ptr_next_s   = ~res_id_r;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
    end
  end

  // Operand capture, only on the accepting edge of the granted requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= '0;
      b_r       <= '0;
      add_sub_r <= 1'b0;
      id_r      <= 1'b0;
    end else if (grant0_s) begin
      a_r       <= req0_a;
      b_r       <= req0_b;
      add_sub_r <= req0_add_sub;
      id_r      <= 1'b0;
    end else if (grant1_s) begin
      a_r       <= req1_a;
      b_r       <= req1_b;
      add_sub_r <= req1_add_sub;
      id_r      <= 1'b1;
    end else begin
      a_r       <= a_r;
      b_r       <= b_r;
      add_sub_r <= add_sub_r;
      id_r      <= id_r;
    end
  end

  // Result registers: loaded in EXEC, held through DONE until the consumer handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_id_r    <= 1'b0;
    end else if (state_r == EXEC) begin
      res_valid_r <= 1'b1;
      res_data_r  <= sum_s;
      res_id_r    <= id_r;
    end else if (res_valid_r && res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;

`ifdef ADDSUB_ARBITER_OVF_EN
  logic res_ovf_r;
  logic ovf_s;

  // Two's-complement overflow: operands of (effective) like sign producing a result of the other sign.
  function automatic logic signed_ovf(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r,
    input logic             add
  );
    logic o;
    if (add) begin
      o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return o;
  endfunction

  assign ovf_s = signed_ovf(a_r, b_r, sum_s, add_sub_r);

  // Overflow flag registered and held alongside res_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_ovf_r <= 1'b0;
    end else if (state_r == EXEC) begin
      res_ovf_r <= ovf_s;
    end else begin
      res_ovf_r <= res_ovf_r;
    end
  end

  assign res_ovf = res_ovf_r;
`endif

endmodule
